// File: rtl/gt_lane_model.sv
// Behavioural GTP channel wrapper: PLL lock, TX/RX reset sequencing, and an
// 18-bit parallel line ({K[1:0], data[15:0]}) with K28.5 byte alignment on receive.
module gt_lane_model #(
    parameter int PLL_LOCK_CYCLES   = 64,
    parameter int TX_RESET_CYCLES   = 16,
    parameter int RX_RESET_CYCLES   = 16,
    parameter int DATA_VALID_CYCLES = 32
) (
    input  logic        sysclk_in,
    input  logic        rst_n,
    input  logic        soft_reset_tx_in,
    input  logic        soft_reset_rx_in,
    input  logic        dont_reset_on_data_error_in,
    input  logic        gt0_data_valid_in,
    input  logic        gt0_txuserrdy_in,
    input  logic        gt0_rxuserrdy_in,
    input  logic [15:0] gt0_txdata_in,
    input  logic [1:0]  gt0_txcharisk_in,
    input  logic        gt0_rxmcommaalignen_in,
    input  logic        gt0_rxpcommaalignen_in,
    input  logic [17:0] gt0_line_rx_in,
    output logic [17:0] gt0_line_tx_out,
    output logic [15:0] gt0_rxdata_out,
    output logic [1:0]  gt0_rxcharisk_out,
    output logic        gt0_rxbyteisaligned_out,
    output logic        gt0_rxcommadet_out,
    output logic        gt0_pll0lock_out,
    output logic        gt0_txresetdone_out,
    output logic        gt0_rxresetdone_out,
    output logic        gt0_tx_fsm_reset_done_out,
    output logic        gt0_rx_fsm_reset_done_out,
    output logic        gt0_txusrclk2_out,
    output logic        gt0_rxusrclk2_out
);

    localparam int PLL_W = $clog2(PLL_LOCK_CYCLES + 1);
    localparam int TX_W  = $clog2(TX_RESET_CYCLES + 1);
    localparam int RX_W  = $clog2(RX_RESET_CYCLES + 1);
    localparam int DV_W  = $clog2(DATA_VALID_CYCLES + 1);

    localparam logic [PLL_W-1:0] PLL_LAST = PLL_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(TX_RESET_CYCLES - 1);
    localparam logic [RX_W-1:0]  RX_LAST  = RX_W'(RX_RESET_CYCLES - 1);
    localparam logic [DV_W-1:0]  DV_FULL  = DV_W'(DATA_VALID_CYCLES);

    typedef enum logic [1:0] {
        TX_WAIT_PLL,
        TX_WAIT_USERRDY,
        TX_RESET,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_WAIT_PLL,
        RX_WAIT_USERRDY,
        RX_RESET,
        RX_WAIT_VALID,
        RX_DONE
    } rx_state_t;

    logic [PLL_W-1:0] pll_cnt_q, pll_cnt_d;
    logic             pll_lock_q, pll_lock_d;

    tx_state_t        tx_state_q, tx_state_d;
    logic [TX_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic             txresetdone_q, txresetdone_d;
    logic             tx_fsm_done_q, tx_fsm_done_d;
    logic [17:0]      line_tx_q, line_tx_d;

    rx_state_t        rx_state_q, rx_state_d;
    logic [RX_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [DV_W-1:0]  dv_cnt_q, dv_cnt_d;
    logic             rxresetdone_q, rxresetdone_d;
    logic             rx_fsm_done_q, rx_fsm_done_d;

    logic [17:0]      rx_in_q, rx_in_d;
    logic [17:0]      rx_out_q, rx_out_d;
    logic             swap_q, swap_d;
    logic             aligned_q, aligned_d;
    logic             commadet_q, commadet_d;

    logic             align_en;
    logic             lo_comma;
    logic             hi_comma;

    // The FSMs leave WAIT_PLL on the same edge the lock flag rises.
    always_comb begin
        pll_lock_d = pll_lock_q | (pll_cnt_q == PLL_LAST);
        pll_cnt_d  = pll_lock_d ? pll_cnt_q : pll_cnt_q + 1'b1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_WAIT_PLL: begin
                if (pll_lock_d) tx_state_d = TX_WAIT_USERRDY;
            end
            TX_WAIT_USERRDY: begin
                if (gt0_txuserrdy_in) begin
                    tx_state_d = TX_RESET;
                    tx_cnt_d   = '0;
                end
            end
            TX_RESET: begin
                if (tx_cnt_q == TX_LAST) tx_state_d = TX_DONE;
                else                     tx_cnt_d   = tx_cnt_q + 1'b1;
            end
            TX_DONE: begin
                tx_state_d = TX_DONE;
            end
            default: tx_state_d = TX_WAIT_PLL;
        endcase
        if (soft_reset_tx_in && (tx_state_q != TX_WAIT_PLL)) begin
            tx_state_d = TX_WAIT_USERRDY;
            tx_cnt_d   = '0;
        end
        txresetdone_d = (tx_state_d == TX_DONE);
        tx_fsm_done_d = (tx_state_q == TX_DONE) && (tx_state_d == TX_DONE);
        line_tx_d     = txresetdone_q ? {gt0_txcharisk_in, gt0_txdata_in} : '0;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        dv_cnt_d   = dv_cnt_q;
        case (rx_state_q)
            RX_WAIT_PLL: begin
                if (pll_lock_d) rx_state_d = RX_WAIT_USERRDY;
            end
            RX_WAIT_USERRDY: begin
                if (gt0_rxuserrdy_in) begin
                    rx_state_d = RX_RESET;
                    rx_cnt_d   = '0;
                end
            end
            RX_RESET: begin
                if (rx_cnt_q == RX_LAST) begin
                    rx_state_d = RX_WAIT_VALID;
                    dv_cnt_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_VALID: begin
                if (!gt0_data_valid_in)      dv_cnt_d   = '0;
                else if (dv_cnt_q == DV_FULL) rx_state_d = RX_DONE;
                else                          dv_cnt_d   = dv_cnt_q + 1'b1;
            end
            RX_DONE: begin
                if (!gt0_data_valid_in && !dont_reset_on_data_error_in) begin
                    rx_state_d = RX_RESET;
                    rx_cnt_d   = '0;
                end
            end
            default: rx_state_d = RX_WAIT_PLL;
        endcase
        if (soft_reset_rx_in && (rx_state_q != RX_WAIT_PLL)) begin
            rx_state_d = RX_RESET;
            rx_cnt_d   = '0;
        end
        rxresetdone_d = (rx_state_d == RX_WAIT_VALID) || (rx_state_d == RX_DONE);
        rx_fsm_done_d = (rx_state_q == RX_DONE) && (rx_state_d == RX_DONE);
    end

    // Comma detection and swap use the live line word; the output word pairs
    // it with the registered previous word, giving two cycles of data latency.
    always_comb begin
        align_en   = gt0_rxmcommaalignen_in | gt0_rxpcommaalignen_in;
        lo_comma   = gt0_line_rx_in[16] && (gt0_line_rx_in[7:0] == 8'hBC);
        hi_comma   = gt0_line_rx_in[17] && (gt0_line_rx_in[15:8] == 8'hBC);
        rx_in_d    = gt0_line_rx_in;
        swap_d     = '0;
        aligned_d  = '0;
        commadet_d = '0;
        rx_out_d   = '0;
        if (rxresetdone_q) begin
            swap_d = swap_q;
            if (align_en && hi_comma)      swap_d = 1'b1;
            else if (align_en && lo_comma) swap_d = 1'b0;
            aligned_d  = aligned_q | (align_en & (hi_comma | lo_comma));
            commadet_d = hi_comma | lo_comma;
            rx_out_d   = swap_q ? {gt0_line_rx_in[16], rx_in_q[17],
                                   gt0_line_rx_in[7:0], rx_in_q[15:8]}
                                : rx_in_q;
        end
    end

    always_ff @(posedge sysclk_in or negedge rst_n) begin
        if (!rst_n) begin
            pll_cnt_q     <= '0;
            pll_lock_q    <= '0;
            tx_state_q    <= TX_WAIT_PLL;
            tx_cnt_q      <= '0;
            txresetdone_q <= '0;
            tx_fsm_done_q <= '0;
            line_tx_q     <= '0;
            rx_state_q    <= RX_WAIT_PLL;
            rx_cnt_q      <= '0;
            dv_cnt_q      <= '0;
            rxresetdone_q <= '0;
            rx_fsm_done_q <= '0;
            rx_in_q       <= '0;
            rx_out_q      <= '0;
            swap_q        <= '0;
            aligned_q     <= '0;
            commadet_q    <= '0;
        end else begin
            pll_cnt_q     <= pll_cnt_d;
            pll_lock_q    <= pll_lock_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            txresetdone_q <= txresetdone_d;
            tx_fsm_done_q <= tx_fsm_done_d;
            line_tx_q     <= line_tx_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            dv_cnt_q      <= dv_cnt_d;
            rxresetdone_q <= rxresetdone_d;
            rx_fsm_done_q <= rx_fsm_done_d;
            rx_in_q       <= rx_in_d;
            rx_out_q      <= rx_out_d;
            swap_q        <= swap_d;
            aligned_q     <= aligned_d;
            commadet_q    <= commadet_d;
        end
    end

    assign gt0_line_tx_out           = line_tx_q;
    assign gt0_rxdata_out            = rx_out_q[15:0];
    assign gt0_rxcharisk_out         = rx_out_q[17:16];
    assign gt0_rxbyteisaligned_out   = aligned_q;
    assign gt0_rxcommadet_out        = commadet_q;
    assign gt0_pll0lock_out          = pll_lock_q;
    assign gt0_txresetdone_out       = txresetdone_q;
    assign gt0_rxresetdone_out       = rxresetdone_q;
    assign gt0_tx_fsm_reset_done_out = tx_fsm_done_q;
    assign gt0_rx_fsm_reset_done_out = rx_fsm_done_q;
    assign gt0_txusrclk2_out         = sysclk_in;
    assign gt0_rxusrclk2_out         = sysclk_in;

endmodule

// File: tb/tb_gt_lane_model.sv
// Bench for gt_lane_model: reset sequencing timeline, alignment vector table,
// randomized RX/TX datapath against a byte-stream model, and restart corner cases.
module tb_gt_lane_model;

    localparam int PLL = 64;
    localparam int TXR = 16;
    localparam int RXR = 16;
    localparam int DVC = 32;
    localparam logic [8:0] COMMA = 9'h1BC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_tx, soft_rx, dont, valid, txrdy, rxrdy;
    logic [15:0] txd;
    logic [1:0]  txk;
    logic        m_en, p_en;
    logic [17:0] rx_drv, line_rx, line_tx;
    logic        loop_en;
    logic [15:0] rxdata;
    logic [1:0]  rxk;
    logic        al, cd, pll, txrd, rxrd, txfsm, rxfsm, txusr, rxusr;

    always #5 clk = ~clk;

    assign line_rx = loop_en ? line_tx : rx_drv;

    gt_lane_model #(
        .PLL_LOCK_CYCLES  (PLL),
        .TX_RESET_CYCLES  (TXR),
        .RX_RESET_CYCLES  (RXR),
        .DATA_VALID_CYCLES(DVC)
    ) dut (
        .sysclk_in                  (clk),
        .rst_n                      (rst_n),
        .soft_reset_tx_in           (soft_tx),
        .soft_reset_rx_in           (soft_rx),
        .dont_reset_on_data_error_in(dont),
        .gt0_data_valid_in          (valid),
        .gt0_txuserrdy_in           (txrdy),
        .gt0_rxuserrdy_in           (rxrdy),
        .gt0_txdata_in              (txd),
        .gt0_txcharisk_in           (txk),
        .gt0_rxmcommaalignen_in     (m_en),
        .gt0_rxpcommaalignen_in     (p_en),
        .gt0_line_rx_in             (line_rx),
        .gt0_line_tx_out            (line_tx),
        .gt0_rxdata_out             (rxdata),
        .gt0_rxcharisk_out          (rxk),
        .gt0_rxbyteisaligned_out    (al),
        .gt0_rxcommadet_out         (cd),
        .gt0_pll0lock_out           (pll),
        .gt0_txresetdone_out        (txrd),
        .gt0_rxresetdone_out        (rxrd),
        .gt0_tx_fsm_reset_done_out  (txfsm),
        .gt0_rx_fsm_reset_done_out  (rxfsm),
        .gt0_txusrclk2_out          (txusr),
        .gt0_rxusrclk2_out          (rxusr)
    );

    logic [4:0]  flags;
    logic [42:0] all_out;
    assign flags   = {rxfsm, txfsm, rxrd, txrd, pll};
    assign all_out = {line_tx, rxdata, rxk, al, cd, pll, txrd, rxrd, txfsm, rxfsm};

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          rise[5];

    typedef struct {
        logic [17:0] line;
        logic        en;
        logic [17:0] exp_rx;
        logic        cd;
        logic        al;
    } vec_t;
    vec_t vt[14];

    logic [8:0]  bq[$];
    logic [8:0]  lo, hi, eh, el;
    logic [17:0] exp_rx;
    logic        off, al_m, cd_m;
    int unsigned sel, n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rise[k] = edge index (1-based from the call) where flag k first goes 0->1, else -1.
    task automatic track(input int unsigned cycles);
        logic [4:0] prev;
        for (int unsigned k = 0; k < 5; k++) rise[k] = -1;
        prev = flags;
        for (int unsigned c = 1; c <= cycles; c++) begin
            tick();
            for (int unsigned k = 0; k < 5; k++)
                if (rise[k] < 0 && flags[k] && !prev[k]) rise[k] = int'(c);
            prev = flags;
        end
    endtask

    task automatic check_bringup(input string tag);
        track(130);
        check({tag, "_pll_rise"},     rise[0], PLL);
        check({tag, "_txrd_rise"},    rise[1], PLL + 1 + TXR);
        check({tag, "_rxrd_rise"},    rise[2], PLL + 1 + RXR);
        check({tag, "_txfsm_rise"},   rise[3], PLL + 1 + TXR + 1);
        check({tag, "_rxfsm_rise"},   rise[4], PLL + 1 + RXR + 1 + DVC + 1);
    endtask

    function automatic logic [8:0] rbyte();
        if ($urandom_range(3) == 0) return COMMA;
        return {($urandom_range(7) == 0), 8'($urandom)};
    endfunction

    initial begin
        vt[0]  = '{{2'b01, 16'h56BC}, 1'b0, {2'b00, 16'h0000}, 1'b1, 1'b0};
        vt[1]  = '{{2'b00, 16'h1234}, 1'b1, {2'b01, 16'h56BC}, 1'b0, 1'b0};
        vt[2]  = '{{2'b01, 16'h50BC}, 1'b1, {2'b00, 16'h1234}, 1'b1, 1'b1};
        vt[3]  = '{{2'b00, 16'h1234}, 1'b1, {2'b01, 16'h50BC}, 1'b0, 1'b1};
        vt[4]  = '{{2'b10, 16'hBC50}, 1'b1, {2'b00, 16'h1234}, 1'b1, 1'b1};
        vt[5]  = '{{2'b00, 16'h3412}, 1'b1, {2'b01, 16'h12BC}, 1'b0, 1'b1};
        vt[6]  = '{{2'b00, 16'h7856}, 1'b1, {2'b00, 16'h5634}, 1'b0, 1'b1};
        vt[7]  = '{{2'b00, 16'h00BC}, 1'b1, {2'b00, 16'hBC78}, 1'b0, 1'b1};
        vt[8]  = '{{2'b01, 16'h9ABC}, 1'b0, {2'b10, 16'hBC00}, 1'b1, 1'b1};
        vt[9]  = '{{2'b00, 16'hDEF0}, 1'b1, {2'b00, 16'hF09A}, 1'b0, 1'b1};
        vt[10] = '{{2'b01, 16'h22BC}, 1'b1, {2'b10, 16'hBCDE}, 1'b1, 1'b1};
        vt[11] = '{{2'b00, 16'h3333}, 1'b1, {2'b01, 16'h22BC}, 1'b0, 1'b1};
        vt[12] = '{{2'b01, 16'h00F7}, 1'b1, {2'b00, 16'h3333}, 1'b0, 1'b1};
        vt[13] = '{{2'b00, 16'h0000}, 1'b1, {2'b01, 16'h00F7}, 1'b0, 1'b1};

        rst_n = 1'b0; soft_tx = 1'b0; soft_rx = 1'b0; dont = 1'b0; valid = 1'b1;
        txrdy = 1'b1; rxrdy = 1'b1; txd = '0; txk = '0; m_en = 1'b0; p_en = 1'b0;
        rx_drv = '0; loop_en = 1'b0;

        #12;
        check("reset_outputs", all_out, '0);
        @(posedge clk); #1;
        check("usrclk_high", {txusr, rxusr}, 2'b11);
        @(negedge clk); #1;
        check("usrclk_low", {txusr, rxusr}, 2'b00);
        tick();
        rst_n = 1'b1;
        check_bringup("bringup");

        for (int unsigned i = 0; i < 14; i++) begin
            rx_drv = vt[i].line;
            m_en   = vt[i].en & ~i[0];
            p_en   = vt[i].en & i[0];
            tick();
            check($sformatf("vec%0d", i), {rxk, rxdata, cd, al},
                  {vt[i].exp_rx, vt[i].cd, vt[i].al});
        end

        bq.delete();
        bq.push_back(9'h000);
        bq.push_back(9'h000);
        off  = 1'b0;
        al_m = 1'b1;
        for (int unsigned j = 0; j < 300; j++) begin
            lo     = rbyte();
            hi     = rbyte();
            sel    = $urandom_range(2);
            m_en   = (sel == 1);
            p_en   = (sel == 2);
            rx_drv = {hi[8], lo[8], hi[7:0], lo[7:0]};
            txd    = 16'($urandom);
            txk    = 2'($urandom);
            tick();
            bq.push_back(lo);
            bq.push_back(hi);
            n = bq.size();
            if (off) {eh, el} = {bq[n-2], bq[n-3]};
            else     {eh, el} = {bq[n-3], bq[n-4]};
            exp_rx = {eh[8], el[8], eh[7:0], el[7:0]};
            cd_m   = (lo == COMMA) || (hi == COMMA);
            if (sel != 0) begin
                al_m = al_m | cd_m;
                if (hi == COMMA)      off = 1'b1;
                else if (lo == COMMA) off = 1'b0;
            end
            check("rand_rx", {rxk, rxdata, cd, al}, {exp_rx, cd_m, al_m});
            check("rand_tx", line_tx, {txk, txd});
            while (bq.size() > 8) void'(bq.pop_front());
        end

        loop_en = 1'b1; m_en = 1'b1; p_en = 1'b0;
        txd = 16'h50BC; txk = 2'b01;
        tick();
        txd = 16'h1234; txk = 2'b00;
        tick();
        tick();
        check("loop_word0", {rxk, rxdata}, {2'b01, 16'h50BC});
        tick();
        check("loop_word1", {rxk, rxdata, al}, {2'b00, 16'h1234, 1'b1});
        loop_en = 1'b0; rx_drv = '0;

        valid = 1'b0;
        tick();
        valid = 1'b1;
        check("dvloss_drop", {rxrd, rxfsm, txrd}, 3'b001);
        tick();
        check("dvloss_rx_cleared", {al, rxdata}, '0);
        track(60);
        check("dvloss_rxrd_rise",  rise[2], RXR - 1);
        check("dvloss_rxfsm_rise", rise[4], RXR + DVC + 1);

        dont = 1'b1; valid = 1'b0;
        tick();
        valid = 1'b1;
        check("dont_reset_hold", {rxrd, rxfsm}, 2'b11);
        repeat (3) tick();
        check("dont_reset_later", {rxrd, rxfsm}, 2'b11);
        dont = 1'b0;

        soft_tx = 1'b1;
        tick();
        tick();
        soft_tx = 1'b0;
        check("softtx_drop", {pll, txrd, txfsm}, 3'b100);
        check("softtx_line_zero", line_tx, '0);
        track(40);
        check("softtx_txrd_rise",  rise[1], TXR + 1);
        check("softtx_txfsm_rise", rise[3], TXR + 2);
        check("softtx_pll_held", pll, 1'b1);

        soft_rx = 1'b1;
        tick();
        soft_rx = 1'b0;
        check("softrx_drop", {rxrd, rxfsm, txrd}, 3'b001);
        track(60);
        check("softrx_rxrd_rise",  rise[2], RXR);
        check("softrx_rxfsm_rise", rise[4], RXR + DVC + 2);

        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", all_out, '0);
        tick();
        rst_n = 1'b1;
        check_bringup("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
